// File: rtl/fc_pkg.sv
// Shared definitions for the fc run controller: state encoding, default run
// parameters, buffer geometry and the saturating write-count helper.
package fc_pkg;

  localparam int FC_AW          = 7;
  localparam int FC_DW          = 32;
  localparam int FC_DEPTH       = 1 << FC_AW;
  localparam int FC_CW          = 8;
  localparam int FC_N_OUT_DEF   = 128;
  localparam int FC_TIMEOUT_DEF = 4096;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } fc_state_e;

  function automatic logic [FC_CW-1:0] fc_sat_inc(input logic [FC_CW-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/fc_result_buf.sv
// 128x32 result buffer: one write port and one registered read port.
// Reading and writing the same address in one cycle returns the old word.
module fc_result_buf
  import fc_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             wr_en_i,
  input  logic [FC_AW-1:0] wr_addr_i,
  input  logic [FC_DW-1:0] wr_data_i,
  input  logic [FC_AW-1:0] rd_addr_i,
  output logic [FC_DW-1:0] rd_data_o
);

  logic [FC_DW-1:0] r_mem [FC_DEPTH];
  logic [FC_DW-1:0] r_rd_data;

  // Storage is left unreset so it maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      r_mem[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= r_mem[rd_addr_i];
    end
  end

  assign rd_data_o = r_rd_data;

endmodule

// File: rtl/fc_run_ctrl.sv
// Run controller for the fc core: sequences one start pulse per host request,
// captures output writes into the result buffer and flags short or stuck runs.
module fc_run_ctrl
  import fc_pkg::*;
#(
  parameter int N_OUT       = FC_N_OUT_DEF,
  parameter int TIMEOUT_CYC = FC_TIMEOUT_DEF
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             host_start_i,
  input  logic             host_clr_i,
  output logic             host_busy_o,
  output logic             host_done_o,
  output logic             host_err_o,
  output logic             fc_start_o,
  input  logic             fc_done_i,
  input  logic             fc_wren_i,
  input  logic [FC_AW-1:0] fc_waddr_i,
  input  logic [FC_DW-1:0] fc_wdata_i,
  input  logic [FC_AW-1:0] rd_addr_i,
  output logic [FC_DW-1:0] rd_data_o,
  output logic [FC_CW-1:0] wr_count_o
);

  localparam int TW = $clog2(TIMEOUT_CYC) + 1;

  fc_state_e        r_state;
  fc_state_e        w_state_next;
  logic [TW-1:0]    r_tmo;
  logic [FC_CW-1:0] r_wr_count;
  logic             w_wr_accept;
  logic             w_tmo_hit;
  logic             w_enter_start;

  assign w_wr_accept   = fc_wren_i && ((r_state == ST_RUN) || (r_state == ST_DRAIN));
  assign w_tmo_hit     = (r_tmo == TW'(TIMEOUT_CYC - 1));
  assign w_enter_start = (r_state == ST_IDLE) && host_start_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // fc_done_i is tested before the timeout so a coincident completion wins.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (host_start_i) w_state_next = ST_START;
      ST_START: w_state_next = ST_RUN;
      ST_RUN: begin
        if (fc_done_i) begin
          w_state_next = ST_DRAIN;
        end else if (w_tmo_hit) begin
          w_state_next = ST_ERR;
        end
      end
      ST_DRAIN: w_state_next = (r_wr_count == FC_CW'(N_OUT)) ? ST_DONE : ST_ERR;
      ST_DONE:  if (host_clr_i) w_state_next = ST_IDLE;
      ST_ERR:   if (host_clr_i) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    fc_start_o  = 1'b0;
    host_busy_o = 1'b0;
    host_done_o = 1'b0;
    host_err_o  = 1'b0;
    case (r_state)
      ST_START: begin
        fc_start_o  = 1'b1;
        host_busy_o = 1'b1;
      end
      ST_RUN:   host_busy_o = 1'b1;
      ST_DRAIN: host_busy_o = 1'b1;
      ST_DONE:  host_done_o = 1'b1;
      ST_ERR:   host_err_o  = 1'b1;
      default:  fc_start_o  = 1'b0;
    endcase
  end

  // Counters restart as START is entered and otherwise hold the last run's values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_tmo      <= '0;
      r_wr_count <= '0;
    end else if (w_enter_start) begin
      r_tmo      <= '0;
      r_wr_count <= '0;
    end else begin
      if (r_state == ST_RUN) begin
        r_tmo <= r_tmo + 1'b1;
      end
      if (w_wr_accept) begin
        r_wr_count <= fc_sat_inc(r_wr_count);
      end
    end
  end

  assign wr_count_o = r_wr_count;

  fc_result_buf u_buf (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .wr_en_i   (w_wr_accept),
    .wr_addr_i (fc_waddr_i),
    .wr_data_i (fc_wdata_i),
    .rd_addr_i (rd_addr_i),
    .rd_data_o (rd_data_o)
  );

endmodule

// File: tb/tb_fc_run_ctrl.sv
// Self-checking bench for fc_run_ctrl: randomized runs compared against a
// behavioural model of the result buffer and run outcome.
module tb_fc_run_ctrl;

   localparam int TO_CYC = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        hostStart, hostClr, fcDone, fcWren;
   logic [6:0]  fcWaddr, rdAddr;
   logic [31:0] fcWdata;
   logic        busy, done, err, fcStart;
   logic [31:0] rdData;
   logic [7:0]  wrCount;

   logic        toStart, toClr, toFcDone, toWren;
   logic [6:0]  toWaddr, toRdAddr;
   logic [31:0] toWdata;
   logic        toBusy, toDone, toErr, toFcStart;
   logic [31:0] toRdData;
   logic [7:0]  toWrCount;

   int errors = 0;
   int checks = 0;
   int startCount = 0;
   int toStartCount = 0;

   logic [31:0] modelMem [128];
   int          modelCount;

   fc_run_ctrl dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .host_start_i(hostStart), .host_clr_i(hostClr),
      .host_busy_o(busy), .host_done_o(done), .host_err_o(err),
      .fc_start_o(fcStart), .fc_done_i(fcDone), .fc_wren_i(fcWren),
      .fc_waddr_i(fcWaddr), .fc_wdata_i(fcWdata),
      .rd_addr_i(rdAddr), .rd_data_o(rdData), .wr_count_o(wrCount)
   );

   fc_run_ctrl #(.N_OUT(128), .TIMEOUT_CYC(TO_CYC)) dut_to (
      .clk_i(clk), .rst_n_i(rst_n),
      .host_start_i(toStart), .host_clr_i(toClr),
      .host_busy_o(toBusy), .host_done_o(toDone), .host_err_o(toErr),
      .fc_start_o(toFcStart), .fc_done_i(toFcDone), .fc_wren_i(toWren),
      .fc_waddr_i(toWaddr), .fc_wdata_i(toWdata),
      .rd_addr_i(toRdAddr), .rd_data_o(toRdData), .wr_count_o(toWrCount)
   );

   always #5 clk = ~clk;

   // Start pulses are counted on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (fcStart === 1'b1) startCount++;
      if (toFcStart === 1'b1) toStartCount++;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic beginRun(input bit holdStart);
      hostStart = 1'b1;
      tick;
      if (!holdStart) hostStart = 1'b0;
      tick;
      modelCount = 0;
   endtask

   task automatic writeOne(input logic [6:0] a, input logic [31:0] d, input bit withDone);
      repeat ($urandom_range(0, 2)) tick;
      fcWren = 1'b1; fcWaddr = a; fcWdata = d; fcDone = withDone;
      tick;
      fcWren = 1'b0; fcDone = 1'b0;
      modelMem[a] = d;
      modelCount++;
   endtask

   task automatic finishRun(input bit doneWithLast);
      if (!doneWithLast) begin
         fcDone = 1'b1;
         tick;
         fcDone = 1'b0;
      end
      tick;
   endtask

   task automatic clearHost;
      hostClr = 1'b1;
      tick;
      hostClr = 1'b0;
   endtask

   task automatic readChecks(input string name, input int n);
      logic [6:0] a;
      for (int j = 0; j < n; j++) begin
         a = 7'($urandom_range(0, 127));
         rdAddr = a;
         tick;
         checks++;
         if (rdData !== modelMem[a]) begin
            errors++;
            $display("[TB] FAIL %s addr=%0d got=%h want=%h", name, a, rdData, modelMem[a]);
         end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, err, fcStart} !== 4'b0000) begin
         errors++;
         $display("[TB] FAIL reset_flags got=%b want=0000", {busy, done, err, fcStart});
      end
      checks++;
      if (wrCount !== 8'd0) begin
         errors++;
         $display("[TB] FAIL reset_count got=%0d want=0", wrCount);
      end
      checks++;
      if (rdData !== 32'd0) begin
         errors++;
         $display("[TB] FAIL reset_rddata got=%h want=0", rdData);
      end
      tick;
      tick;
      rst_n = 1'b1;
      tick;
   endtask

   task automatic test_normal_run;
      int s0;
      s0 = startCount;
      hostStart = 1'b1;
      tick;
      checks++;
      if (fcStart !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL normal_start_pulse got start=%b busy=%b want 1 1", fcStart, busy);
      end
      hostStart = 1'b0;
      tick;
      modelCount = 0;
      for (int i = 0; i < 128; i++) writeOne(7'(i), 32'(i * 3), 1'b0);
      finishRun(1'b0);
      checks++;
      if ({busy, done, err} !== {1'b0, modelCount == 128, modelCount != 128}) begin
         errors++;
         $display("[TB] FAIL normal_outcome got busy/done/err=%b%b%b want 010", busy, done, err);
      end
      checks++;
      if (wrCount !== 8'(modelCount)) begin
         errors++;
         $display("[TB] FAIL normal_count got=%0d want=%0d", wrCount, modelCount);
      end
      checks++;
      if (startCount - s0 !== 1) begin
         errors++;
         $display("[TB] FAIL normal_start_count got=%0d want=1", startCount - s0);
      end
      rdAddr = 7'd5;
      tick;
      checks++;
      if (rdData !== 32'd15) begin
         errors++;
         $display("[TB] FAIL normal_rd5 got=%0d want=15", rdData);
      end
      readChecks("normal_read", 4);
      clearHost;
      checks++;
      if ({busy, done, err} !== 3'b000 || wrCount !== 8'd128) begin
         errors++;
         $display("[TB] FAIL normal_clear got flags=%b count=%0d want 000 128", {busy, done, err}, wrCount);
      end
   endtask

   task automatic test_short_run;
      int s0;
      beginRun(1'b0);
      for (int i = 0; i < 127; i++) writeOne(7'($urandom_range(0, 127)), $urandom, 1'b0);
      finishRun(1'b0);
      checks++;
      if ({done, err} !== 2'b01) begin
         errors++;
         $display("[TB] FAIL short_outcome got done/err=%b%b want 01", done, err);
      end
      checks++;
      if (wrCount !== 8'(modelCount)) begin
         errors++;
         $display("[TB] FAIL short_count got=%0d want=%0d", wrCount, modelCount);
      end
      s0 = startCount;
      hostStart = 1'b1;
      tick;
      tick;
      hostStart = 1'b0;
      checks++;
      if (err !== 1'b1 || startCount != s0) begin
         errors++;
         $display("[TB] FAIL short_start_ignored got err=%b starts=%0d want 1 0", err, startCount - s0);
      end
      readChecks("short_read", 6);
      clearHost;
      checks++;
      if ({busy, done, err} !== 3'b000) begin
         errors++;
         $display("[TB] FAIL short_clear got=%b want=000", {busy, done, err});
      end
   endtask

   task automatic test_done_with_last;
      beginRun(1'b0);
      for (int i = 0; i < 128; i++) writeOne(7'($urandom_range(0, 127)), $urandom, i == 127);
      finishRun(1'b1);
      checks++;
      if ({done, err} !== 2'b10) begin
         errors++;
         $display("[TB] FAIL lastdone_outcome got done/err=%b%b want 10", done, err);
      end
      checks++;
      if (wrCount !== 8'd128) begin
         errors++;
         $display("[TB] FAIL lastdone_count got=%0d want=128", wrCount);
      end
      readChecks("lastdone_read", 6);
   endtask

   task automatic test_ignored_inputs;
      int s0;
      hostClr = 1'b1;
      tick;
      tick;
      hostClr = 1'b0;
      fcWren = 1'b1; fcWaddr = 7'd5; fcWdata = 32'hDEAD_BEEF;
      tick;
      tick;
      fcWren = 1'b0;
      checks++;
      if (wrCount !== 8'd128) begin
         errors++;
         $display("[TB] FAIL stray_count got=%0d want=128", wrCount);
      end
      rdAddr = 7'd5;
      tick;
      checks++;
      if (rdData !== modelMem[5]) begin
         errors++;
         $display("[TB] FAIL stray_data got=%h want=%h", rdData, modelMem[5]);
      end
      s0 = startCount;
      beginRun(1'b1);
      for (int i = 0; i < 128; i++) writeOne(7'(i), $urandom, 1'b0);
      finishRun(1'b0);
      repeat (3) tick;
      checks++;
      if (startCount - s0 !== 1 || done !== 1'b1) begin
         errors++;
         $display("[TB] FAIL held_start got starts=%0d done=%b want 1 1", startCount - s0, done);
      end
      fcWren = 1'b1; fcWaddr = 7'd7; fcWdata = ~modelMem[7];
      tick;
      fcWren = 1'b0;
      checks++;
      if (wrCount !== 8'd128) begin
         errors++;
         $display("[TB] FAIL done_stray_count got=%0d want=128", wrCount);
      end
      readChecks("held_read", 4);
      rdAddr = 7'd7;
      tick;
      checks++;
      if (rdData !== modelMem[7]) begin
         errors++;
         $display("[TB] FAIL done_stray_data got=%h want=%h", rdData, modelMem[7]);
      end
      hostStart = 1'b0;
      clearHost;
   endtask

   task automatic test_back_to_back;
      logic [6:0]  a;
      logic [31:0] oldD, newD;
      beginRun(1'b0);
      a = 7'($urandom_range(0, 127));
      oldD = modelMem[a];
      newD = ~oldD ^ 32'h1357_9BDF;
      rdAddr = a; fcWren = 1'b1; fcWaddr = a; fcWdata = newD;
      tick;
      fcWren = 1'b0;
      modelMem[a] = newD;
      modelCount++;
      checks++;
      if (rdData !== oldD) begin
         errors++;
         $display("[TB] FAIL rw_collision got=%h want=%h", rdData, oldD);
      end
      tick;
      checks++;
      if (rdData !== newD) begin
         errors++;
         $display("[TB] FAIL rw_after got=%h want=%h", rdData, newD);
      end
      for (int i = 1; i < 128; i++) writeOne(7'($urandom_range(0, 127)), $urandom, 1'b0);
      finishRun(1'b0);
      checks++;
      if (done !== 1'b1 || wrCount !== 8'd128) begin
         errors++;
         $display("[TB] FAIL b2b_outcome got done=%b count=%0d want 1 128", done, wrCount);
      end
      clearHost;
   endtask

   task automatic test_reset_mid_run;
      int s0;
      beginRun(1'b0);
      for (int i = 0; i < 40; i++) writeOne(7'($urandom_range(0, 127)), $urandom, 1'b0);
      checks++;
      if (wrCount !== 8'd40 || busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL midrun_pre got count=%0d busy=%b want 40 1", wrCount, busy);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, err, fcStart} !== 4'b0000 || wrCount !== 8'd0 || rdData !== 32'd0) begin
         errors++;
         $display("[TB] FAIL midrun_reset got flags=%b count=%0d rd=%h want 0000 0 0",
                  {busy, done, err, fcStart}, wrCount, rdData);
      end
      tick;
      tick;
      rst_n = 1'b1;
      s0 = startCount;
      repeat (5) tick;
      checks++;
      if (startCount != s0 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midrun_idle got starts=%0d busy=%b want 0 0", startCount - s0, busy);
      end
      beginRun(1'b0);
      for (int i = 0; i < 128; i++) writeOne(7'(i), $urandom, 1'b0);
      finishRun(1'b0);
      checks++;
      if (done !== 1'b1 || wrCount !== 8'd128 || startCount - s0 !== 1) begin
         errors++;
         $display("[TB] FAIL midrun_rerun got done=%b count=%0d starts=%0d want 1 128 1",
                  done, wrCount, startCount - s0);
      end
      readChecks("midrun_read", 4);
      clearHost;
   endtask

   task automatic test_timeout;
      int k;
      bit found;
      toStart = 1'b1;
      tick;
      toStart = 1'b0;
      tick;
      checks++;
      if (toBusy !== 1'b1 || toStartCount !== 1) begin
         errors++;
         $display("[TB] FAIL timeout_enter got busy=%b starts=%0d want 1 1", toBusy, toStartCount);
      end
      found = 1'b0;
      k = 0;
      for (int i = 1; i <= 40 && !found; i++) begin
         tick;
         if (toErr === 1'b1) begin
            found = 1'b1;
            k = i;
         end
      end
      checks++;
      if (!found || k != TO_CYC) begin
         errors++;
         $display("[TB] FAIL timeout_cycles got found=%0d cycles=%0d want %0d", found, k, TO_CYC);
      end
      checks++;
      if (toBusy !== 1'b0 || toWrCount !== 8'd0) begin
         errors++;
         $display("[TB] FAIL timeout_state got busy=%b count=%0d want 0 0", toBusy, toWrCount);
      end
      toClr = 1'b1;
      tick;
      toClr = 1'b0;
      checks++;
      if (toErr !== 1'b0) begin
         errors++;
         $display("[TB] FAIL timeout_clear got err=%b want 0", toErr);
      end
   endtask

   initial begin
      hostStart = 1'b0; hostClr = 1'b0; fcDone = 1'b0; fcWren = 1'b0;
      fcWaddr = '0; fcWdata = '0; rdAddr = '0;
      toStart = 1'b0; toClr = 1'b0; toFcDone = 1'b0; toWren = 1'b0;
      toWaddr = '0; toWdata = '0; toRdAddr = '0;
      rst_n = 1'b1;
      modelCount = 0;
      #2;
      test_reset;
      test_normal_run;
      test_short_run;
      test_done_with_last;
      test_ignored_inputs;
      test_back_to_back;
      test_reset_mid_run;
      test_timeout;
      $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fc_run_ctrl.md
FC_RUN_CTRL -- requirements
Module: fc_run_ctrl

Interface
REQ-001 SHALL have parameter N_OUT, default 128: expected number of fc output writes per run.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 4096: maximum cycles allowed in RUN before an error is flagged.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n_i, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port host_start_i, input, 1 bit: run request, sampled each cycle.
REQ-006 SHALL have port host_clr_i, input, 1 bit: acknowledges DONE/ERR and returns to IDLE.
REQ-007 SHALL have port host_busy_o, output, 1 bit: high in START, RUN and DRAIN.
REQ-008 SHALL have port host_done_o, output, 1 bit: high while in DONE.
REQ-009 SHALL have port host_err_o, output, 1 bit: high while in ERR.
REQ-010 SHALL have port fc_start_o, output, 1 bit: single-cycle start pulse to the fc core.
REQ-011 SHALL have port fc_done_i, input, 1 bit: completion pulse from the fc core.
REQ-012 SHALL have port fc_wren_i, input, 1 bit: fc output write strobe.
REQ-013 SHALL have port fc_waddr_i, input, 7 bits: fc output write address.
REQ-014 SHALL have port fc_wdata_i, input, 32 bits: fc output write data.
REQ-015 SHALL have port rd_addr_i, input, 7 bits: host result read address.
REQ-016 SHALL have port rd_data_o, output, 32 bits: host result read data.
REQ-017 SHALL have port wr_count_o, output, 8 bits: accepted-write count for the current/last run.

Function
REQ-018 FSM states SHALL be IDLE, START, RUN, DRAIN, DONE, ERR.
- IDLE->START on host_start_i.
- START->RUN unconditionally after 1 cycle.
- RUN->DRAIN on fc_done_i.
- DRAIN->DONE if wr_count==N_OUT, else DRAIN->ERR.
- RUN->ERR when the timeout counter reaches TIMEOUT_CYC-1 with fc_done_i low.
- DONE/ERR->IDLE on host_clr_i.
REQ-019 fc_start_o SHALL be high exactly in START (one cycle per run); a host_start_i held high SHALL NOT retrigger until IDLE is re-entered.
REQ-020 host_start_i SHALL be ignored outside IDLE.
REQ-021 host_clr_i SHALL be ignored outside DONE/ERR.
REQ-022 Entering START SHALL clear wr_count and the timeout counter.
REQ-023 The timeout counter SHALL increment each cycle in RUN.
REQ-024 fc_done_i and timeout expiry in the same cycle SHALL resolve to DRAIN (done wins).
REQ-025 Writes with fc_wren_i high in RUN or DRAIN SHALL store fc_wdata_i at fc_waddr_i in a 128x32 result buffer and increment wr_count, saturating at 255.
REQ-026 A write in the same cycle as fc_done_i SHALL be accepted (DRAIN absorbs a trailing write).
REQ-027 Writes in IDLE, START, DONE or ERR SHALL be discarded and SHALL NOT be counted.
REQ-028 A repeated address SHALL overwrite the stored entry and still be counted.
REQ-029 rd_data_o SHALL be the buffer entry at the rd_addr_i sampled on the previous edge (1-cycle latency), in any state.
REQ-030 A read and a write to the same address in the same cycle SHALL return the old data.
REQ-031 After DONE, buffer contents and wr_count SHALL hold until the next START.

Reset
REQ-032 On rst_n_i low: state=IDLE, fc_start_o=0, host_busy_o=0, host_done_o=0, host_err_o=0, wr_count_o=0, timeout counter=0, rd_data_o=0, taking effect immediately.
REQ-033 The buffer array SHALL NOT be reset; its contents are undefined until written.
REQ-034 Reset mid-RUN SHALL return to IDLE with no further fc_start_o pulse.

Structure
REQ-035 State encoding, N_OUT and TIMEOUT_CYC defaults, and the 7-bit address and 32-bit data widths SHALL live in a shared package, fc_pkg.
REQ-036 The result buffer SHALL be a separate sub-module, fc_result_buf: 1 write port, 1 synchronous read port, inferable as block RAM.

Verification
REQ-037 Normal run: pulse start; model issues 128 writes (data=addr*3) then fc_done_i -> exactly one fc_start_o; DONE; wr_count=128; rd_addr 5 returns 15 on the next cycle.
REQ-038 Short run: 127 writes then fc_done_i -> ERR; wr_count=127; host_clr_i -> IDLE.
REQ-039 Timeout with TIMEOUT_CYC=16: no fc_done_i -> host_err_o rises 16 cycles after entering RUN.
REQ-040 Same-cycle done and final write: 128th write coincides with fc_done_i -> DONE; wr_count=128.
REQ-041 Ignored inputs: host_start_i held high through the run, plus stray writes in IDLE -> single fc_start_o; stray data not stored; wr_count unaffected.
REQ-042 Reset mid-RUN after 40 writes -> all outputs 0 immediately; a subsequent start runs normally.
